// File: rtl/face_fetcher_pkg.sv
// Shared types for the face ROM read path: face word, face index and fetch FSM states.
package face_fetcher_pkg;

  localparam int FACE_CNT_DEFAULT = 92;
  localparam int FACE_IDX_W       = $clog2(FACE_CNT_DEFAULT);

  typedef logic [FACE_IDX_W-1:0] FaceIdx_t;

  // One triangle: three packed vertex words as stored in the face ROM.
  typedef struct packed {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] v2;
  } Face_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } FetchState_t;

  // Index width that stays legal for a single-entry ROM.
  function automatic int idx_width(input int cnt);
    return (cnt > 1) ? $clog2(cnt) : 1;
  endfunction

endpackage

// File: rtl/face_skid_buffer.sv
// Two-entry FIFO skid buffer with push/pop, flush and occupancy; payload width is generic
// so the same block can carry faces or ray results.
module face_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A push into a full buffer is only taken when the same edge frees a slot.
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_occ   = r_count;

endmodule

// File: rtl/face_fetcher.sv
// Walks the face ROM once per start and streams faces in index order over valid/ready.
// Optional FACE_FETCH_ABORT_EN adds an abort input that cancels the current pass.
module face_fetcher
  import face_fetcher_pkg::*;
#(
  parameter int  FACE_CNT = FACE_CNT_DEFAULT,
  parameter int  ROM_LAT  = 1,
  localparam int IDX_W    = idx_width(FACE_CNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef FACE_FETCH_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic [IDX_W-1:0] face_cntr,
  input  Face_t            rom_face_data,
  output logic             face_valid,
  input  logic             face_ready,
  output Face_t            face_out,
  output logic [IDX_W-1:0] face_idx,
  output logic             face_last,
  output logic             done,
  output FetchState_t      dbg_state
);

  // Handshake: a face transfers on every edge where face_valid && face_ready; while
  // face_valid is high and face_ready low, face_out/face_idx/face_last hold steady.

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FACE_CNT - 1);
  localparam int               ENTRY_W  = $bits(Face_t) + IDX_W;

  generate
    if (ROM_LAT != 1) begin : g_rom_lat_check
      $error("face_fetcher supports ROM_LAT == 1 only");
    end
  endgenerate

  FetchState_t        r_state;
  FetchState_t        w_state_nxt;
  logic [IDX_W-1:0]   r_face_cntr;
  logic               r_inflight;
  logic [IDX_W-1:0]   r_inflight_idx;
  logic               w_issue;
  logic               w_pop;
  logic               w_abort;
  logic               w_drained;
  logic               w_done;
  logic [2:0]         w_fill;
  logic [1:0]         w_occ;
  logic               w_fifo_valid;
  logic [ENTRY_W-1:0] w_fifo_data;

`ifdef FACE_FETCH_ABORT_EN
  assign w_abort = abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_pop     = w_fifo_valid && face_ready;
  // Entries the buffer will hold once the current read lands and the current pop leaves.
  assign w_fill    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = (r_state == STREAM) && (w_fill < 3'd2) && !w_abort;
  assign w_drained = (w_occ == 2'd0) && !r_inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_abort || (w_issue && (r_face_cntr == LAST_IDX))) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drained) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The address saturates at the last face so DRAIN holds it there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_face_cntr <= '0;
    end else if (w_abort || ((r_state == IDLE) && start)) begin
      r_face_cntr <= '0;
    end else if (w_issue && (r_face_cntr != LAST_IDX)) begin
      r_face_cntr <= r_face_cntr + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight     <= 1'b0;
      r_inflight_idx <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_idx <= r_face_cntr;
      end
    end
  end

  face_skid_buffer #(
    .W (ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_abort),
    .i_push  (r_inflight),
    .i_data  ({rom_face_data, r_inflight_idx}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_valid (w_fifo_valid),
    .o_occ   (w_occ)
  );

  assign {face_out, face_idx} = w_fifo_data;
  assign face_valid = w_fifo_valid;
  assign face_last  = w_fifo_valid && (face_idx == LAST_IDX);
  assign face_cntr  = r_face_cntr;
  assign busy       = (r_state != IDLE);
  assign done       = w_done;
  assign dbg_state  = r_state;

endmodule
